obstacle_scheduler: RTL

Game-sequencing controller for the HEROE obstacle field. It owns the game state machine (`presente`), advances the 3-lane × 7-column obstacle field (`display_obs`) on a programmable step period, and draws new obstacle patterns (`tipo_obs`) from a 4-bit LFSR (`r_reg`). It also tracks the hero lane from keypad events, detects collisions, scores cleared columns, and speeds the game up. It sits between the keypad decoder and the display driver. Its outputs are the signals probed by the on-chip logic analyser.

---
 rtl/heroe_pkg.sv | 33 +++
 rtl/obstacle_lfsr.sv | 15 +
 rtl/obstacle_scheduler.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/heroe_pkg.sv
// Shared types, constants and the obstacle mask helper for the HEROE
// obstacle field.
package heroe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_HIT  = 3'd2,
    ST_OVER = 3'd3
  } state_t;

  localparam logic [3:0] KEY_UP    = 4'h2;
  localparam logic [3:0] KEY_DOWN  = 4'h8;
  localparam logic [3:0] KEY_START = 4'h5;

  localparam int LANES = 3;
  localparam int COLS  = 7;

  localparam logic [3:0] LFSR_SEED = 4'h9;

  // Base lane from tipo[1:0] (3 = empty), tipo[3] adds the next lane up mod 3.
  function automatic logic [2:0] obs_mask(input logic [3:0] tipo);
    logic [2:0] m;
    case (tipo[1:0])
      2'd0:    m = tipo[3] ? 3'b011 : 3'b001;
      2'd1:    m = tipo[3] ? 3'b110 : 3'b010;
      2'd2:    m = tipo[3] ? 3'b101 : 3'b100;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/obstacle_lfsr.sv
// Free-running 4-bit Fibonacci LFSR (x^4+x^3+1), seeded on reset.
module obstacle_lfsr
  import heroe_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] value
);

  always_ff @(posedge clk) begin
    if (!rst_n) value <= LFSR_SEED;
    else        value <= {value[2:0], value[3] ^ value[2]};
  end

endmodule

// File: rtl/obstacle_scheduler.sv
// HEROE game sequencer: FSM, obstacle field shifting/spawning, hero lane,
// collision detection, scoring and step-period speed-up.
module obstacle_scheduler
  import heroe_pkg::*;
#(
  parameter int TICK_DIV     = 25_000_000,
  parameter int TICK_MIN     = 6_250_000,
  parameter int SPEEDUP_STEP = 1_000_000,
  parameter int HIT_CYCLES   = 12_500_000
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        keypad_pressed,
  input  logic [3:0]  key_code,
  output logic [2:0]  presente,
  output logic [20:0] display_obs,
  output logic [1:0]  hero_lane,
  output logic [3:0]  tipo_obs,
  output logic [3:0]  r_reg,
  output logic [7:0]  score,
  output logic        step,
  output logic        game_over
);

  localparam logic [31:0] PERIOD_INIT = 32'(TICK_DIV);
  localparam logic [31:0] PERIOD_MIN  = 32'(TICK_MIN);
  localparam logic [31:0] PERIOD_DEC  = 32'(SPEEDUP_STEP);
  localparam logic [31:0] HIT_LAST    = 32'(HIT_CYCLES - 1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [31:0] faster(input logic [31:0] p);
    return (p >= PERIOD_MIN + PERIOD_DEC) ? p - PERIOD_DEC : PERIOD_MIN;
  endfunction

  function automatic logic [20:0] shift_field(input logic [20:0] f, input logic [2:0] col6);
    logic [20:0] n;
    n = '0;
    for (int l = 0; l < LANES; l++) begin
      n[l*COLS +: COLS-1]  = f[l*COLS+1 +: COLS-1];
      n[l*COLS + COLS - 1] = col6[l];
    end
    return n;
  endfunction

  state_t      state, state_nxt;
  logic [31:0] cnt, cnt_nxt, period, period_nxt;
  logic [20:0] field_nxt;
  logic [1:0]  lane_nxt;
  logic [7:0]  score_nxt, score_inc;
  logic [3:0]  tipo_nxt;
  logic        gap, gap_nxt, step_nxt;
  logic [2:0]  col0;
  logic        key_up, key_down, key_start, collide;

  obstacle_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .value (r_reg)
  );

  assign presente  = state;
  assign col0      = {display_obs[2*COLS], display_obs[COLS], display_obs[0]};
  assign collide   = col0[hero_lane];
  assign key_up    = keypad_pressed && (key_code == KEY_UP);
  assign key_down  = keypad_pressed && (key_code == KEY_DOWN);
  assign key_start = keypad_pressed && (key_code == KEY_START);
  assign score_inc = sat_inc(score);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    period_nxt = period;
    field_nxt  = display_obs;
    lane_nxt   = hero_lane;
    score_nxt  = score;
    tipo_nxt   = tipo_obs;
    gap_nxt    = gap;
    step_nxt   = 1'b0;
    case (state)
      ST_IDLE: if (key_start) state_nxt = ST_RUN;
      ST_RUN: begin
        // A collision freezes everything else on this edge.
        if (collide) begin
          state_nxt = ST_HIT;
          cnt_nxt   = '0;
        end else begin
          if (key_up && hero_lane < 2'd2)   lane_nxt = hero_lane + 2'd1;
          if (key_down && hero_lane > 2'd0) lane_nxt = hero_lane - 2'd1;
          if (cnt == period - 32'd1) begin
            cnt_nxt  = '0;
            step_nxt = 1'b1;
            if (col0 != 3'b000) begin
              score_nxt = score_inc;
              if (score_inc != score && score_inc[2:0] == 3'd0) period_nxt = faster(period);
            end
            if (gap) begin
              field_nxt = shift_field(display_obs, 3'b000);
              gap_nxt   = 1'b0;
            end else begin
              field_nxt = shift_field(display_obs, obs_mask(r_reg));
              tipo_nxt  = r_reg;
              gap_nxt   = 1'b1;
            end
          end else begin
            cnt_nxt = cnt + 32'd1;
          end
        end
      end
      ST_HIT: begin
        if (cnt == HIT_LAST) begin
          state_nxt = ST_OVER;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 32'd1;
        end
      end
      ST_OVER: if (key_start) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    // IDLE holds a fresh game; clearing on entry makes it visible immediately.
    if (state_nxt == ST_IDLE) begin
      field_nxt  = '0;
      score_nxt  = '0;
      period_nxt = PERIOD_INIT;
      lane_nxt   = 2'd1;
      gap_nxt    = 1'b0;
      cnt_nxt    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      period      <= PERIOD_INIT;
      display_obs <= '0;
      hero_lane   <= 2'd1;
      score       <= '0;
      tipo_obs    <= '0;
      gap         <= 1'b0;
      step        <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      period      <= period_nxt;
      display_obs <= field_nxt;
      hero_lane   <= lane_nxt;
      score       <= score_nxt;
      tipo_obs    <= tipo_nxt;
      gap         <= gap_nxt;
      step        <= step_nxt;
      game_over   <= (state_nxt == ST_OVER);
    end
  end

endmodule
